// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions used by the fetch stage and its consumers.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_flow_t;

endpackage

// File: rtl/if_stage_fetch_queue.sv
// Synchronous circular FIFO with flush; pop_data always shows the head entry.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full queue can still take a push when the head leaves the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= incr(wr_ptr);
            if (do_pop)  rd_ptr <= incr(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC owner, credit-limited imem requester and in-order fetch queue.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output if_id_flow_t outflow,
    output logic        out_valid
);
    localparam int CW  = $clog2(QUEUE_DEPTH + 1);
    localparam int CW1 = CW + 1;

    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] q_count;
    logic [31:0]   tag_pc;
    logic          tag_full;
    logic          tag_empty;
    logic          q_full;
    logic          q_empty;
    if_id_flow_t   q_head;
    if_id_flow_t   q_in;
    logic [CW:0]   credits_used;
    logic          fire;
    logic          resp_take;
    logic          q_push;
    logic          q_pop;
    logic [CW-1:0] resp_dec;

    assign credits_used   = {1'b0, q_count} + {1'b0, tag_count};
    assign imem_req_valid = !reset && !redirect_valid && (credits_used < CW1'(QUEUE_DEPTH));
    assign imem_addr      = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    assign resp_take = imem_resp_valid && !tag_empty;
    assign resp_dec  = resp_take ? CW'(1) : '0;
    assign q_push    = resp_take && (drop_cnt == '0) && !redirect_valid;
    assign q_pop     = !q_empty && !stall && !redirect_valid;
    assign q_in      = '{pc: tag_pc, instr: imem_resp_data};

    assign out_valid = !q_empty;
    assign outflow   = q_empty ? '{pc: 32'h0, instr: NOP_INSTR} : q_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~32'h3;
            // Nothing issues this cycle, so what remains in flight is the tag count minus today's response.
            drop_cnt <= tag_count - resp_dec;
        end else begin
            if (fire) pc <= pc + 32'd4;
            if (resp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Tags are never flushed on redirect: dropped responses still have to retire them.
    fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH(32)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (fire),
        .push_data (pc),
        .pop       (resp_take),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_queue #(.DEPTH(QUEUE_DEPTH), .WIDTH($bits(if_id_flow_t))) u_fetch_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_in),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    a_no_q_overflow:   assert property (@(posedge clk) disable iff (reset) !(q_push && q_full && !q_pop));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (reset) !(fire && tag_full));

endmodule
